// File: rtl/keccak_word_serializer.sv
// Captures one wide Keccak output and returns OUT_W-bit words either by
// registered random access or as a valid/ready streamed burst.
module keccak_word_serializer #(
    parameter  int IN_W  = 512,
    parameter  int OUT_W = 32,
    localparam int N     = IN_W / OUT_W,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [IN_W-1:0]    in_data,
    output logic               buf_full,
    input  logic               rd_en,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [OUT_W-1:0]   rd_data,
    output logic               rd_valid,
    input  logic               start,
    input  logic [IDX_W:0]     len,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               done,
    output logic               err
);

    localparam logic [0:0]     IDLE   = 1'b0;
    localparam logic [0:0]     STREAM = 1'b1;
    localparam logic [IDX_W:0] N_LEN  = (IDX_W + 1)'(N);

    logic [0:0]       state_q, state_d;
    logic [IN_W-1:0]  buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic [OUT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] last_q, last_d;

    logic [OUT_W-1:0] words [N];
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cnt_inc;
    logic [OUT_W-1:0] sel_word;
    logic [IDX_W:0]   req_len;
    logic [IDX_W:0]   eff_len;
    logic             len_over;

    for (genvar k = 0; k < N; k++) begin : g_words
        assign words[k] = buf_q[k*OUT_W +: OUT_W];
    end

    assign cnt_inc  = cnt_q + 1'b1;
    assign sel_word = words[sel_idx];

    // One shared word mux: IDLE serves reads or the first burst word, STREAM the next word.
    always_comb begin
        sel_idx = cnt_inc;
        if (state_q == IDLE) begin
            sel_idx = start ? '0 : rd_idx;
        end
    end

    always_comb begin
        req_len  = (len == '0) ? N_LEN : len;
        len_over = (req_len > N_LEN);
        eff_len  = len_over ? N_LEN : req_len;
    end

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;
        last_d      = last_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    buf_d      = in_data;
                    buf_full_d = 1'b1;
                    err_d      = 1'b0;
                end else if (start) begin
                    if (buf_full_q) begin
                        state_d     = STREAM;
                        cnt_d       = '0;
                        last_d      = IDX_W'(eff_len - 1'b1);
                        out_valid_d = 1'b1;
                        out_data_d  = sel_word;
                        out_last_d  = (eff_len == (IDX_W + 1)'(1));
                        if (len_over) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (rd_en) begin
                    rd_valid_d = 1'b1;
                    if (({1'b0, rd_idx} >= N_LEN) || !buf_full_q) begin
                        rd_data_d = '0;
                        err_d     = 1'b1;
                    end else begin
                        rd_data_d = sel_word;
                    end
                end
            end
            default: begin
                if (load) begin
                    err_d = 1'b1;
                end
                if (out_valid_q && out_ready) begin
                    if (cnt_q == last_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                        buf_full_d  = 1'b0;
                    end else begin
                        cnt_d      = cnt_inc;
                        out_data_d = sel_word;
                        out_last_d = (cnt_inc == last_q);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
        end
    end

    assign buf_full  = buf_full_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_keccak_word_serializer.sv
// Self-checking bench for keccak_word_serializer: default 512/32 instance plus
// a 1600/64 instance, checked against constants and a word-array model.
module tb_keccak_word_serializer;

    logic         clk = 1'b0;
    logic         reset;

    logic         load, rd_en, start, out_ready;
    logic [511:0] in_data;
    logic [3:0]   rd_idx;
    logic [4:0]   len;
    logic         buf_full, rd_valid, out_valid, out_last, done, err;
    logic [31:0]  rd_data, out_data;

    logic          b_load, b_rd_en;
    logic [1599:0] b_in_data;
    logic [4:0]    b_rd_idx;
    logic          b_buf_full, b_rd_valid, b_out_valid, b_out_last, b_done, b_err;
    logic [63:0]   b_rd_data, b_out_data;
    logic [63:0]   b_top;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mwords [16];
    logic        model_full;
    logic        model_err;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] exp_data;
        logic        exp_err;
    } rd_vec_t;
    rd_vec_t rd_vecs [3];

    always #5 clk = ~clk;

    keccak_word_serializer dut (
        .clk(clk), .reset(reset), .load(load), .in_data(in_data),
        .buf_full(buf_full), .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_data(rd_data), .rd_valid(rd_valid), .start(start), .len(len),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done), .err(err)
    );

    keccak_word_serializer #(.IN_W(1600), .OUT_W(64)) dut_b (
        .clk(clk), .reset(reset), .load(b_load), .in_data(b_in_data),
        .buf_full(b_buf_full), .rd_en(b_rd_en), .rd_idx(b_rd_idx),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .start(1'b0), .len(6'd0),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(1'b0),
        .out_last(b_out_last), .done(b_done), .err(b_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load();
        for (int k = 0; k < 16; k++) in_data[k*32 +: 32] = mwords[k];
        load = 1'b1;
        step();
        load = 1'b0;
        model_full = 1'b1;
        model_err  = 1'b0;
        check("load_buf_full", buf_full, 1'b1);
        check("load_err", err, 1'b0);
    endtask

    task automatic do_read(input logic [3:0] idx);
        logic [31:0] exp;
        rd_en  = 1'b1;
        rd_idx = idx;
        step();
        rd_en = 1'b0;
        if (model_full) begin
            exp = mwords[idx];
        end else begin
            exp = '0;
            model_err = 1'b1;
        end
        check("rd_valid", rd_valid, 1'b1);
        check("rd_data", rd_data, exp);
        check("rd_err", err, model_err);
    endtask

    // Consumer side of a burst already presenting word 0.
    task automatic stream_body(input int L, input bit use_rand, input logic [15:0] pat);
        int  k   = 0;
        int  cyc = 0;
        logic r;
        while (k < L && cyc < 200) begin
            check("out_valid", out_valid, 1'b1);
            check("out_data", out_data, mwords[k]);
            check("out_last", out_last, (k == L - 1));
            check("done_in_burst", done, 1'b0);
            r = use_rand ? 1'($urandom_range(0, 1)) : ((cyc < 16) ? pat[cyc] : 1'b1);
            out_ready = r;
            if (r && out_valid) k++;
            step();
            cyc++;
        end
        out_ready = 1'b0;
        if (k < L) check("stream_timeout", 64'(k), 64'(L));
        model_full = 1'b0;
        check("done_pulse", done, 1'b1);
        check("post_valid", out_valid, 1'b0);
        check("post_last", out_last, 1'b0);
        check("post_buf_full", buf_full, 1'b0);
        step();
        check("done_single", done, 1'b0);
    endtask

    task automatic run_stream(input logic [4:0] len_in, input bit use_rand, input logic [15:0] pat);
        int L;
        L = (len_in == 0) ? 16 : int'(len_in);
        start = 1'b1;
        len   = len_in;
        step();
        start = 1'b0;
        if (!model_full) begin
            model_err = 1'b1;
            check("start_empty_valid", out_valid, 1'b0);
            check("start_empty_err", err, 1'b1);
        end else begin
            if (L > 16) begin
                L = 16;
                model_err = 1'b1;
            end
            stream_body(L, use_rand, pat);
            check("stream_err", err, model_err);
        end
    endtask

    initial begin
        reset = 1'b0;
        {load, rd_en, start, out_ready} = '0;
        in_data = '0; rd_idx = '0; len = '0;
        b_load = 1'b0; b_rd_en = 1'b0; b_in_data = '0; b_rd_idx = '0;
        model_full = 1'b0;
        model_err  = 1'b0;
        for (int k = 0; k < 16; k++) mwords[k] = 32'hA500_0000 + k;
        rd_vecs[0] = '{4'd0,  32'hA500_0000, 1'b0};
        rd_vecs[1] = '{4'd7,  32'hA500_0007, 1'b0};
        rd_vecs[2] = '{4'd15, 32'hA500_000F, 1'b0};

        repeat (3) step();
        check("rst_buf_full", buf_full, 1'b0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        reset = 1'b1;
        step();

        // Wide instance: 25 words of 64 bits.
        for (int k = 0; k < 25; k++) b_in_data[k*64 +: 64] = {$urandom, $urandom};
        b_top  = b_in_data[1599:1536];
        b_load = 1'b1;
        step();
        b_load = 1'b0;
        b_rd_en = 1'b1; b_rd_idx = 5'd24;
        step();
        check("b_rd_valid_24", b_rd_valid, 1'b1);
        check("b_rd_data_24", b_rd_data, b_top);
        check("b_err_24", b_err, 1'b0);
        b_rd_idx = 5'd30;
        step();
        b_rd_en = 1'b0;
        check("b_rd_valid_30", b_rd_valid, 1'b1);
        check("b_rd_data_30", b_rd_data, 64'h0);
        check("b_err_30", b_err, 1'b1);
        b_load = 1'b1;
        step();
        b_load = 1'b0;
        check("b_err_cleared", b_err, 1'b0);

        do_load();
        for (int i = 0; i < 3; i++) begin
            rd_en  = 1'b1;
            rd_idx = rd_vecs[i].idx;
            step();
            rd_en = 1'b0;
            check("vec_rd_valid", rd_valid, 1'b1);
            check("vec_rd_data", rd_data, rd_vecs[i].exp_data);
            check("vec_err", err, rd_vecs[i].exp_err);
        end
        step();
        check("rd_valid_pulse", rd_valid, 1'b0);
        check("rd_data_hold", rd_data, 32'hA500_000F);

        run_stream(5'd0, 1'b0, 16'hFFFF);
        do_read(4'd2);

        model_err = 1'b0;
        do_load();
        run_stream(5'd4, 1'b0, 16'h0059);

        run_stream(5'd3, 1'b0, 16'hFFFF);

        // Load during a burst is refused and flagged.
        do_load();
        start = 1'b1; len = 5'd0;
        step();
        start = 1'b0;
        load = 1'b1; in_data = {16{32'hDEAD_BEEF}};
        step();
        load = 1'b0;
        model_err = 1'b1;
        check("midload_err", err, 1'b1);
        check("midload_data", out_data, mwords[0]);
        stream_body(16, 1'b0, 16'hFFFF);
        check("midload_err_sticky", err, 1'b1);

        // load+start together: only the load happens.
        for (int k = 0; k < 16; k++) mwords[k] = $urandom;
        for (int k = 0; k < 16; k++) in_data[k*32 +: 32] = mwords[k];
        load = 1'b1; start = 1'b1; len = 5'd0;
        step();
        load = 1'b0; start = 1'b0;
        model_full = 1'b1; model_err = 1'b0;
        check("ls_out_valid", out_valid, 1'b0);
        check("ls_buf_full", buf_full, 1'b1);
        check("ls_err", err, 1'b0);
        do_read(4'd3);

        // Asynchronous reset with word 5 pending.
        start = 1'b1; len = 5'd0;
        step();
        start = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();
        out_ready = 1'b0;
        check("pre_rst_data", out_data, mwords[5]);
        #2 reset = 1'b0;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_buf_full", buf_full, 1'b0);
        check("async_done", done, 1'b0);
        step();
        check("rst_hold_done", done, 1'b0);
        reset = 1'b1;
        model_full = 1'b0; model_err = 1'b0;
        step();
        check("post_rst_done", done, 1'b0);
        do_load();
        run_stream(5'd0, 1'b0, 16'hFFFF);

        // Randomized traffic against the word-array model.
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    for (int k = 0; k < 16; k++) mwords[k] = $urandom;
                    do_load();
                end
                1: do_read(4'($urandom_range(0, 15)));
                default: run_stream(5'($urandom_range(0, 20)), 1'b1, 16'h0000);
            endcase
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keccak_word_serializer.md
Name: keccak_word_serializer

Overview:
- Parametrised successor of the fixed 512→32 Keccak word selector.
- Captures one wide Keccak output (digest or full state) into an internal buffer. Returns OUT_W-bit words two ways: registered random access by index, or a valid/ready streamed burst.
- Sits between the Keccak core and keccak_ctrl / the custom-instruction read path.

Parameters:
- IN_W, 512: width of captured input. Must be a multiple of OUT_W; 1600 is also supported.
- OUT_W, 32: output word width.
- N, IN_W/OUT_W: word count (derived, not overridable).
- IDX_W, clog2(N), minimum 1: width of index and length fields.

Ports:
- clk  in  1  clock, all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- load  in  1  capture in_data into buffer
- in_data  in  IN_W  wide input word; word k = in_data[k*OUT_W +: OUT_W]
- buf_full  out  1  buffer holds valid data
- rd_en  in  1  random-access read request
- rd_idx  in  IDX_W  word index for random read
- rd_data  out  OUT_W  registered random-read result
- rd_valid  out  1  one-cycle pulse, rd_data valid
- start  in  1  begin streamed burst
- len  in  IDX_W+1  words to stream; 0 means N
- out_data  out  OUT_W  stream word
- out_valid  out  1  stream word valid
- out_ready  in  1  consumer accepts word
- out_last  out  1  final word of burst, qualified by out_valid
- done  out  1  one-cycle pulse after last stream handshake
- err  out  1  sticky error flag; cleared only by reset or accepted load

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0: buf_full, rd_data, rd_valid, out_data, out_valid, out_last, done, err. Buffer contents don't-care.
- States: IDLE, STREAM.
- Load:
  - Accepted only in IDLE: buffer <= in_data, buf_full=1, err=0 next cycle.
  - load in STREAM is ignored and sets err=1.
- Random read (IDLE only, rd_en=1):
  - Next cycle: rd_valid=1, rd_data=word[rd_idx].
  - rd_data holds its value until the next read.
  - rd_idx >= N or buf_full=0: rd_valid=1, rd_data=0, err=1.
  - rd_en in STREAM: ignored, no rd_valid.
- Stream start (IDLE, start=1, buf_full=1):
  - Effective length L = (len==0) ? N : len.
  - L > N: clamp to N, set err=1.
  - Next cycle: STREAM, out_valid=1, out_data=word[0], out_last=(L==1).
  - start with buf_full=0: ignored, err=1.
- STREAM:
  - Handshake = out_valid & out_ready.
  - out_data/out_last stable while out_valid & !out_ready.
  - On handshake with k < L-1: next word k+1 presented the following cycle. No bubble; back-to-back handshakes give 1 word/cycle.
  - On handshake of word L-1: next cycle out_valid=0, out_last=0, done=1 for one cycle, buf_full=0, state IDLE.
  - start in STREAM: ignored, no err.
- Simultaneous events in IDLE, priority load > start > rd_en:
  - load+start: load taken; start dropped.
  - start+rd_en: burst begins, no rd_valid.
- load in the same cycle done pulses is accepted, since the state is already IDLE.
- Reset mid-burst: out_valid drops immediately (async); buffer invalid; no done.
- Word select is a registered mux on a word counter of IDX_W bits. No combinational path from in_data to outputs.

Test Plan:
- Reset, then load in_data = {16 words, word k = 32'hA5000000+k}, rd_en with rd_idx=0,7,15 → rd_valid pulse each next cycle, rd_data = A5000000, A5000007, A500000F; err=0.
- Stream len=0, out_ready=1 held → 16 consecutive out_valid cycles, data A5000000..A500000F, out_last only on the 16th. done pulses the cycle after; buf_full=0.
- Stream len=4, out_ready toggling 1,0,0,1,1,0,1 → each word held while out_ready=0; exactly 4 words A5000000..A5000003 accepted; out_last on word 3; done once.
- IN_W=1600, OUT_W=64 (N=25): rd_idx=24 → top 64 bits returned. rd_idx=30 → rd_data=0, err=1. Then a load clears err.
- Error paths: start with buf_full=0 → no out_valid, err=1. load mid-burst → burst data unchanged, err=1. load+start same cycle in IDLE → only load takes effect.
- Assert reset=0 while word 5 of 16 is pending → out_valid/buf_full go 0 without a clock edge; no done pulse. Release, then reload and stream → burst restarts at word 0.
